// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the sequencing control unit.
//   - state_t      : FSM state encoding (also exported on the debug port)
//   - CLS_*        : opcode class in opcode[OPCODE_W-1:OPCODE_W-2]
//   - SUB_J*       : jump condition selector in opcode[1:0] (jump class)
//   - MISC_*       : sub-operation in opcode[1:0] (misc class)
//   - OP_W_DEF / OPCODE_W_DEF : default field widths
package cpu_ctrl_pkg;

    localparam int OP_W_DEF     = 2;
    localparam int OPCODE_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_JUMP    = 2'b10;
    localparam logic [1:0] CLS_MISC    = 2'b11;

    localparam logic [1:0] SUB_JMP = 2'b00;
    localparam logic [1:0] SUB_JC  = 2'b01;
    localparam logic [1:0] SUB_JZ  = 2'b10;
    localparam logic [1:0] SUB_JS  = 2'b11;

    localparam logic [1:0] MISC_CMP = 2'b00;
    localparam logic [1:0] MISC_NOP = 2'b01;
    localparam logic [1:0] MISC_ILL = 2'b10;
    localparam logic [1:0] MISC_HLT = 2'b11;

    // ALU classes and CMP drive the ALU op field and capture the flags.
    function automatic logic uses_alu(input logic [1:0] cls, input logic [1:0] sub);
        return (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM) ||
               ((cls == CLS_MISC) && (sub == MISC_CMP));
    endfunction

endpackage

// File: rtl/ctrl_flag_reg.sv
// ctrl_flag_reg: 3-bit latched flag register plus branch-condition evaluation.
//   clk, rst_n          : clock, async active-low reset (flags clear to 0)
//   load                : capture cf_in/zf_in/sf_in at this clock edge
//   cf_in, zf_in, sf_in : live ALU flags
//   cond_sel            : jump selector (JMP/JC/JZ/JS)
//   cf, zf, sf          : latched flags
//   cond_true           : selected condition evaluated on the latched flags
module ctrl_flag_reg
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       cf_in,
    input  logic       zf_in,
    input  logic       sf_in,
    input  logic [1:0] cond_sel,
    output logic       cf,
    output logic       zf,
    output logic       sf,
    output logic       cond_true
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cf <= 1'b0;
            zf <= 1'b0;
            sf <= 1'b0;
        end else if (load) begin
            cf <= cf_in;
            zf <= zf_in;
            sf <= sf_in;
        end
    end

    // Evaluated on the latched flags, i.e. the state left by earlier
    // instructions; jumps never load the register.
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            SUB_JMP: cond_true = 1'b1;
            SUB_JC:  cond_true = cf;
            SUB_JZ:  cond_true = zf;
            SUB_JS:  cond_true = sf;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
//   Inputs : clk, rst_n (async active-low), start, imem_ack, opcode,
//            cf_in/zf_in/sf_in (live ALU flags, valid in EXECUTE)
//   Outputs: imem_req, ir_load, op, im_sel, reg_en, jmp_sel, pc_inc,
//            cf/zf/sf (latched flags), halted, fault (sticky),
//            dbg_state (current FSM state)
//
// Fetch handshake: imem_req is high for every FETCH cycle; a cycle with
// imem_req=1 and imem_ack=1 transfers the instruction word, ir_load
// pulses in that same cycle and the FSM moves to DECODE. imem_req drops
// once the transfer has happened. TIMEOUT_CYC consecutive cycles without
// ack set fault and park the FSM in HALT.
module seq_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int OPCODE_W    = OPCODE_W_DEF,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                imem_ack,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf_in,
    input  logic                zf_in,
    input  logic                sf_in,
    output logic                imem_req,
    output logic                ir_load,
    output logic [OP_W-1:0]     op,
    output logic                im_sel,
    output logic                reg_en,
    output logic                jmp_sel,
    output logic                pc_inc,
    output logic                cf,
    output logic                zf,
    output logic                sf,
    output logic                halted,
    output logic                fault,
    output state_t              dbg_state
);

    state_t     state;
    logic [7:0] to_cnt;
    logic [1:0] cls;
    logic [1:0] sub;
    logic       alu_cls;
    logic       cond_true;

    assign cls       = opcode[OPCODE_W-1:OPCODE_W-2];
    assign sub       = opcode[1:0];
    assign alu_cls   = uses_alu(cls, sub);
    assign dbg_state = state;

    // The only combinational output: the IR must load in the ack cycle.
    assign ir_load = (state == S_FETCH) && imem_ack;

    ctrl_flag_reg u_flags (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      ((state == S_EXECUTE) && alu_cls),
        .cf_in     (cf_in),
        .zf_in     (zf_in),
        .sf_in     (sf_in),
        .cond_sel  (sub),
        .cf        (cf),
        .zf        (zf),
        .sf        (sf),
        .cond_true (cond_true)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            to_cnt   <= '0;
            imem_req <= 1'b0;
            op       <= '0;
            im_sel   <= 1'b0;
            reg_en   <= 1'b0;
            jmp_sel  <= 1'b0;
            pc_inc   <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            reg_en  <= 1'b0;
            jmp_sel <= 1'b0;
            pc_inc  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state    <= S_DECODE;
                        imem_req <= 1'b0;
                        to_cnt   <= '0;
                    end else if (to_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        state    <= S_HALT;
                        imem_req <= 1'b0;
                        to_cnt   <= '0;
                        fault    <= 1'b1;
                        halted   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if ((cls == CLS_MISC) && (sub == MISC_ILL)) begin
                        state  <= S_HALT;
                        fault  <= 1'b1;
                        halted <= 1'b1;
                    end else if ((cls == CLS_MISC) && (sub == MISC_HLT)) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        // op/im_sel are set here and held through WRITEBACK.
                        state  <= S_EXECUTE;
                        op     <= alu_cls ? opcode[OP_W-1:0] : '0;
                        im_sel <= (cls == CLS_ALU_IMM);
                    end
                end
                S_EXECUTE: begin
                    state  <= S_WRITEBACK;
                    reg_en <= (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM);
                    if (cls == CLS_JUMP) begin
                        jmp_sel <= cond_true;
                        pc_inc  <= !cond_true;
                    end else begin
                        pc_inc <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    op       <= '0;
                    im_sel   <= 1'b0;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
module tb_seq_control_unit;
    import cpu_ctrl_pkg::*;

    localparam int W = 13;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       imem_ack;
    logic [3:0] opcode;
    logic       cf_in, zf_in, sf_in;
    logic       imem_req, ir_load, im_sel, reg_en, jmp_sel, pc_inc;
    logic [1:0] op;
    logic       cf, zf, sf, halted, fault;
    state_t     dbg_state;

    always #5 clk = ~clk;

    seq_control_unit #(.OP_W(2), .OPCODE_W(4), .TIMEOUT_CYC(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_ack  (imem_ack),
        .opcode    (opcode),
        .cf_in     (cf_in),
        .zf_in     (zf_in),
        .sf_in     (sf_in),
        .imem_req  (imem_req),
        .ir_load   (ir_load),
        .op        (op),
        .im_sel    (im_sel),
        .reg_en    (reg_en),
        .jmp_sel   (jmp_sel),
        .pc_inc    (pc_inc),
        .cf        (cf),
        .zf        (zf),
        .sf        (sf),
        .halted    (halted),
        .fault     (fault),
        .dbg_state (dbg_state)
    );

    logic [W-1:0] act_vec;
    assign act_vec = {imem_req, ir_load, op, im_sel, reg_en, jmp_sel, pc_inc,
                      cf, zf, sf, halted, fault};

    // ---------------- model state / scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    bit           m_cf, m_zf, m_sf;
    int           cnt_reg = 0, cnt_jmp = 0, cnt_pci = 0;

    function automatic logic [W-1:0] mk(input bit req, input bit irl, input logic [1:0] o,
                                        input bit ims, input bit rg, input bit js,
                                        input bit pi, input bit hl, input bit fl);
        return {req, irl, o, ims, rg, js, pi, m_cf, m_zf, m_sf, hl, fl};
    endfunction

    // one compare process, every scheduled cycle
    always @(negedge clk) begin
        logic [W-1:0] e;
        string        t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (act_vec !== e) begin
                n_fail++;
                $display("FAIL %s got=%b exp=%b (req irl op ims reg jmp pci cf zf sf hlt flt)",
                         t, act_vec, e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_en)  cnt_reg++;
            if (jmp_sel) cnt_jmp++;
            if (pc_inc)  cnt_pci++;
        end
    end

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input bit ack, input bit c, input bit z, input bit s,
                               input logic [W-1:0] e, input string tag);
        @(posedge clk); #1;
        imem_ack = ack;
        cf_in    = c;
        zf_in    = z;
        sf_in    = s;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        imem_ack = 1'b0;
        m_cf = 0; m_zf = 0; m_sf = 0;
        repeat (2) @(posedge clk);
        #1;
        check1("reset_outputs", 32'(act_vec), 32'd0);
        check1("reset_state_idle", 32'(dbg_state == S_IDLE), 32'd1);
        rst_n = 1'b1;
    endtask

    // IDLE with start low, then IDLE with start high -> FETCH next
    task automatic begin_run();
        drive_cycle(0, 0, 0, 0, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0), "idle_wait");
        @(posedge clk); #1;
        start = 1'b1;
        exp_q.push_back(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
        tag_q.push_back("idle_start");
    endtask

    // Expected trace of one instruction derived from its class rules.
    task automatic run_instr(input logic [3:0] opc, input int misses,
                             input bit c, input bit z, input bit s);
        bit         alu, cmp, jmp, hlt, ill, taken;
        logic [1:0] eop;
        bit         eim;
        alu = !opc[3];
        jmp = (opc[3:2] == 2'b10);
        cmp = (opc == 4'b1100);
        hlt = (opc == 4'b1111);
        ill = (opc == 4'b1110);
        for (int i = 0; i < misses; i++)
            drive_cycle(0, 0, 0, 0, mk(1, 0, 2'd0, 0, 0, 0, 0, 0, 0), "fetch_wait");
        drive_cycle(1, 0, 0, 0, mk(1, 1, 2'd0, 0, 0, 0, 0, 0, 0), "fetch_ack");
        opcode = opc;
        drive_cycle(0, 0, 0, 0, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0), "decode");
        if (hlt || ill) begin
            for (int i = 0; i < 4; i++)
                drive_cycle(0, c, z, s, mk(0, 0, 2'd0, 0, 0, 0, 0, 1, ill), "halt_hold");
            return;
        end
        eop = (alu || cmp) ? opc[1:0] : 2'd0;
        eim = (opc[3:2] == 2'b01);
        drive_cycle(0, c, z, s, mk(0, 0, eop, eim, 0, 0, 0, 0, 0), "execute");
        case (opc[1:0])
            2'd0:    taken = 1'b1;
            2'd1:    taken = m_cf;
            2'd2:    taken = m_zf;
            default: taken = m_sf;
        endcase
        if (alu || cmp) begin
            m_cf = c; m_zf = z; m_sf = s;
        end
        drive_cycle(0, 0, 0, 0,
                    mk(0, 0, eop, eim, alu, jmp && taken, !(jmp && taken), 0, 0),
                    "writeback");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; opcode = 4'd0;
        cf_in = 1'b0; zf_in = 1'b0; sf_in = 1'b0;
        m_cf = 0; m_zf = 0; m_sf = 0;

        do_reset();
        begin_run();

        // ALU reg op 0001
        run_instr(4'b0001, 0, 0, 0, 0);
        settle();
        check1("alu_reg_reg_en_pulses", 32'(cnt_reg), 32'd1);
        check1("alu_reg_pc_inc_pulses", 32'(cnt_pci), 32'd1);

        // ALU imm op 0110, flags 1/0/1
        run_instr(4'b0110, 0, 1, 0, 1);
        settle();
        check1("imm_cf", 32'(cf), 32'd1);
        check1("imm_zf", 32'(zf), 32'd0);
        check1("imm_sf", 32'(sf), 32'd1);
        check1("imm_reg_en_pulses", 32'(cnt_reg), 32'd2);

        // CMP zf=1 then JZ taken
        run_instr(4'b1100, 0, 0, 1, 0);
        run_instr(4'b1010, 0, 1, 0, 1);
        settle();
        check1("jz_taken_jmp_pulses", 32'(cnt_jmp), 32'd1);
        check1("jz_taken_pc_inc_pulses", 32'(cnt_pci), 32'd3);
        check1("jz_keeps_zf", 32'(zf), 32'd1);

        // CMP zf=0 then JZ not taken
        run_instr(4'b1100, 0, 0, 0, 0);
        run_instr(4'b1010, 0, 1, 1, 1);
        settle();
        check1("jz_not_taken_jmp_pulses", 32'(cnt_jmp), 32'd1);
        check1("jz_not_taken_pc_inc_pulses", 32'(cnt_pci), 32'd5);

        // remaining jump kinds, NOP ignoring flags, ALU with fetch stalls
        run_instr(4'b1100, 1, 1, 0, 0);
        run_instr(4'b1001, 0, 0, 0, 0);   // JC taken
        run_instr(4'b1011, 2, 0, 0, 0);   // JS not taken
        run_instr(4'b1000, 0, 0, 0, 0);   // JMP always
        run_instr(4'b1101, 0, 1, 1, 1);   // NOP: flags held
        settle();
        check1("nop_holds_cf", 32'(cf), 32'd1);
        check1("nop_holds_sf", 32'(sf), 32'd0);
        check1("jumps_total", 32'(cnt_jmp), 32'd3);
        run_instr(4'b0011, 3, 0, 1, 1);
        run_instr(4'b0010, 13, 1, 1, 0);  // ack on FETCH cycle 14
        run_instr(4'b0101, 14, 0, 0, 1);  // ack on FETCH cycle 15, last legal
        settle();
        check1("late_ack_no_fault", 32'(fault), 32'd0);
        check1("late_ack_reg_en_pulses", 32'(cnt_reg), 32'd5);

        // async reset during EXECUTE of an ALU op
        drive_cycle(1, 0, 0, 0, mk(1, 1, 2'd0, 0, 0, 0, 0, 0, 0), "fetch_ack");
        opcode = 4'b0111;
        drive_cycle(0, 0, 0, 0, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0), "decode");
        @(posedge clk); #1;
        cf_in = 1'b1; zf_in = 1'b1; sf_in = 1'b1;
        #2;
        check1("pre_reset_in_execute", 32'(dbg_state == S_EXECUTE), 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        m_cf = 0; m_zf = 0; m_sf = 0;
        #1;
        check1("async_reset_state_idle", 32'(dbg_state == S_IDLE), 32'd1);
        check1("async_reset_outputs", 32'(act_vec), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check1("async_reset_no_reg_en", 32'(cnt_reg), 32'd5);
        rst_n = 1'b1;

        // restart after reset, then fetch timeout
        begin_run();
        run_instr(4'b0000, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++)
            drive_cycle(0, 0, 0, 0, mk(1, 0, 2'd0, 0, 0, 0, 0, 0, 0), "timeout_wait");
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 0, 0, 0, mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 1), "timeout_halt");
        settle();
        check1("timeout_fault", 32'(fault), 32'd1);
        check1("timeout_halted", 32'(halted), 32'd1);

        // HLT: no pc_inc, start ignored
        do_reset();
        begin_run();
        cnt_pci = 0;
        run_instr(4'b1111, 0, 0, 0, 0);
        settle();
        check1("hlt_halted", 32'(halted), 32'd1);
        check1("hlt_no_fault", 32'(fault), 32'd0);
        check1("hlt_no_pc_inc", 32'(cnt_pci), 32'd0);
        check1("hlt_state", 32'(dbg_state == S_HALT), 32'd1);

        // illegal opcode
        do_reset();
        begin_run();
        run_instr(4'b1110, 1, 0, 0, 0);
        settle();
        check1("ill_fault", 32'(fault), 32'd1);
        check1("ill_halted", 32'(halted), 32'd1);

        repeat (2) @(posedge clk);
        check1("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
Multi-cycle sequencing control unit for the next-generation CPU core. It replaces the purely combinational decoder with a fetch/decode/execute/writeback state machine, a latched flag register, a full conditional-jump set (JMP/JC/JZ/JS), halt, and a handshaked instruction fetch with timeout fault detection. It sits between the instruction register/PC logic and the ALU/register-file datapath, and drives one-cycle strobes into both.

Parameters:
OP_W, 2, width of the ALU operation field; taken from the low OP_W bits of the opcode.
OPCODE_W, 4, opcode width; must be at least OP_W+2.
TIMEOUT_CYC, 15, maximum cycles FETCH waits for imem_ack before raising fault; range 1..255.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE when 1
imem_ack  in  1  instruction memory has valid word this cycle
opcode  in  OPCODE_W  opcode field from the instruction register; stable from DECODE through WRITEBACK
cf_in, zf_in, sf_in  in  1 each  live ALU flags, valid during EXECUTE
imem_req  out  1  fetch request, held high in FETCH until ack
ir_load  out  1  one-cycle strobe: load the instruction register
op  out  OP_W  ALU operation
im_sel  out  1  ALU B operand = immediate
reg_en  out  1  one-cycle register-file write strobe
jmp_sel  out  1  one-cycle strobe: PC <= jump target
pc_inc  out  1  one-cycle strobe: PC <= PC+1
cf, zf, sf  out  1 each  latched flag register
halted  out  1  in HALT state
fault  out  1  sticky; fetch timeout or illegal opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. Flags 0. Timeout counter 0. Fault cleared. Reset mid-instruction aborts it with no strobes.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: outputs 0. start=1 -> FETCH.
- FETCH: imem_req=1. On imem_ack=1, ir_load=1 in that same cycle -> DECODE. The counter increments on each cycle without ack. After TIMEOUT_CYC cycles without ack, fault=1 -> HALT. The counter clears on leaving FETCH.
- DECODE: one cycle, no strobes. Classify the opcode using opcode[OPCODE_W-1:OPCODE_W-2] plus the low bits:
  - 00: ALU register op.
  - 01: ALU immediate op.
  - 10: jump; low 2 bits select 00 JMP, 01 JC, 10 JZ, 11 JS.
  - 11: with low 2 bits 00 CMP, 01 NOP, 10 illegal, 11 HLT.
- EXECUTE: one cycle.
  - op = opcode[OP_W-1:0] for ALU and CMP classes, else 0.
  - im_sel=1 only for the immediate class.
  - ALU and CMP classes latch cf/zf/sf from *_in at the end of EXECUTE. Other classes hold the flags.
- WRITEBACK: one cycle, then FETCH.
  - ALU reg/imm: reg_en=1, pc_inc=1.
  - CMP and NOP: pc_inc=1 only.
  - Jumps: the condition uses latched flags as they stood before this instruction (JMP is always taken). Taken: jmp_sel=1, pc_inc=0. Not taken: pc_inc=1.
  - jmp_sel and pc_inc are mutually exclusive in every cycle.
- HLT in DECODE -> HALT with no pc_inc. Illegal opcode -> fault=1, then HALT.
- HALT: halted=1, all strobes 0. Only rst_n exits HALT; start is ignored.
- op and im_sel are held through EXECUTE and WRITEBACK so the ALU result is stable for the write.
- Instruction latency: 4 cycles (FETCH with immediate ack, DECODE, EXECUTE, WRITEBACK). Each cycle without ack adds one cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - State enum.
  - Opcode class constants and jump/misc sub-opcode constants.
  - Default OP_W and OPCODE_W.
- Natural sub-module: ctrl_flag_reg, the 3-bit flag register with load enable and branch-condition evaluation. The FSM stays in the top module.

Test Plan:
- Reset then start=1, imem_ack immediate, opcode=0001 -> ir_load in cycle 1; op=01, im_sel=0 in EXECUTE; reg_en=1 and pc_inc=1 in cycle 4 only.
- opcode=0110 with cf_in=1, zf_in=0, sf_in=1 in EXECUTE -> im_sel=1, op=10, flags latch cf=1 zf=0 sf=1, reg_en pulse.
- CMP (1100) producing zf_in=1, then JZ (1010) -> jmp_sel=1, pc_inc=0. Repeat with zf_in=0 -> pc_inc=1, jmp_sel=0.
- imem_ack held 0 for TIMEOUT_CYC=15 cycles -> fault=1 and halted=1 on the next cycle, no strobes. With ack arriving at cycle 14 -> normal completion.
- opcode 1111 -> halted=1, no pc_inc, stays halted with start=1. Opcode 1110 -> fault=1, halted=1.
- Assert rst_n=0 during EXECUTE of an ALU op -> no reg_en, flags 0, state IDLE immediately (asynchronous).
